// File: rtl/floppy_pkg.sv
// Shared floppy constants, state encoding and CRC-16/CCITT helper.
// Used by both the sector write and read paths.
package floppy_pkg;

  localparam logic [7:0]  MFM_A1      = 8'hA1;
  localparam logic [7:0]  DAM_NORMAL  = 8'hFB;
  localparam logic [7:0]  DAM_DELETED = 8'hFA;
  localparam logic [7:0]  GAP_BYTE    = 8'h4E;
  localparam logic [7:0]  SYNC_BYTE   = 8'h00;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'h1021;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SYNC   = 4'd1,
    ST_MARK   = 4'd2,
    ST_DAM    = 4'd3,
    ST_DATA   = 4'd4,
    ST_CRC_HI = 4'd5,
    ST_CRC_LO = 4'd6,
    ST_GAP    = 4'd7,
    ST_DONE   = 4'd8
  } wr_state_t;

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  data
  );
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_ccitt.sv
// Byte-wide CRC-16/CCITT accumulator, MSB first.
// i_Init has priority over i_En.
module crc16_ccitt
  import floppy_pkg::*;
(
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic        i_Init,
  input  logic        i_En,
  input  logic [7:0]  i_Data,
  output logic [15:0] o_Crc
);

  logic [15:0] r_Crc;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Crc <= CRC_INIT;
    end else if (i_Init) begin
      r_Crc <= CRC_INIT;
    end else if (i_En) begin
      r_Crc <= crc16_byte(r_Crc, i_Data);
    end
  end

  assign o_Crc = r_Crc;

endmodule

// File: rtl/sector_data_writer.sv
// MFM data-field formatter: sync, A1 marks, data mark, payload,
// CRC and gap, streamed through a one-entry output register.
module sector_data_writer
  import floppy_pkg::*;
#(
  parameter int SECTOR_SIZE = 512,
  parameter int SYNC_LEN    = 12,
  parameter int GAP_LEN     = 24
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Start,
  input  logic       i_Deleted,
  input  logic       i_Abort,
  input  logic [7:0] i_Data,
  input  logic       i_DataValid,
  output logic       o_DataReady,
  output logic [7:0] o_Data,
  output logic       o_Mark,
  output logic       o_Valid,
  input  logic       i_Ready,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam logic [9:0] L_SYNC = 10'(SYNC_LEN - 1);
  localparam logic [9:0] L_MARK = 10'd2;
  localparam logic [9:0] L_DATA = 10'(SECTOR_SIZE - 1);
  localparam logic [9:0] L_GAP  = 10'(GAP_LEN - 1);
  localparam logic [9:0] L_GAPW = 10'(GAP_LEN);

  wr_state_t   r_State;
  logic [9:0]  r_Cnt;
  logic        r_Del;
  logic        r_Valid;
  logic [7:0]  r_Data;
  logic        r_Mark;
  logic        r_Busy;
  logic        r_Done;

  logic        w_Adv;
  logic        w_Accept;
  logic        w_Has;
  logic [7:0]  w_Byte;
  logic        w_MarkBit;
  logic        w_CrcEn;
  logic        w_Load;
  logic        w_CrcInit;
  logic [15:0] w_Crc;

  assign w_Adv    = !r_Valid || i_Ready;
  assign w_Accept = r_Valid && i_Ready;

  always_comb begin
    w_Has     = 1'b0;
    w_Byte    = SYNC_BYTE;
    w_MarkBit = 1'b0;
    w_CrcEn   = 1'b0;
    unique case (r_State)
      ST_SYNC: begin
        w_Has  = 1'b1;
        w_Byte = SYNC_BYTE;
      end
      ST_MARK: begin
        w_Has     = 1'b1;
        w_Byte    = MFM_A1;
        w_MarkBit = 1'b1;
        w_CrcEn   = 1'b1;
      end
      ST_DAM: begin
        w_Has   = 1'b1;
        w_Byte  = r_Del ? DAM_DELETED : DAM_NORMAL;
        w_CrcEn = 1'b1;
      end
      ST_DATA: begin
        w_Has   = i_DataValid && (r_Cnt <= L_DATA);
        w_Byte  = i_Data;
        w_CrcEn = 1'b1;
      end
      ST_CRC_HI: begin
        w_Has  = 1'b1;
        w_Byte = w_Crc[15:8];
      end
      ST_CRC_LO: begin
        w_Has  = 1'b1;
        w_Byte = w_Crc[7:0];
      end
      // count parks at GAP_LEN while the last gap byte drains
      ST_GAP: begin
        w_Has  = (r_Cnt != L_GAPW);
        w_Byte = GAP_BYTE;
      end
      default: begin
        w_Has = 1'b0;
      end
    endcase
  end

  assign w_Load    = w_Has && w_Adv;
  assign w_CrcInit = (r_State == ST_IDLE) && i_Start;

  assign o_DataReady = (r_State == ST_DATA) && w_Adv
                       && (r_Cnt <= L_DATA);

  crc16_ccitt u_crc (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .i_Init    (w_CrcInit),
    .i_En      (w_Load && w_CrcEn),
    .i_Data    (w_Byte),
    .o_Crc     (w_Crc)
  );

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State <= ST_IDLE;
      r_Cnt   <= '0;
      r_Del   <= 1'b0;
      r_Valid <= 1'b0;
      r_Data  <= '0;
      r_Mark  <= 1'b0;
      r_Busy  <= 1'b0;
      r_Done  <= 1'b0;
    end else if (i_Abort && (r_State != ST_IDLE)) begin
      r_State <= ST_IDLE;
      r_Cnt   <= '0;
      r_Valid <= 1'b0;
      r_Mark  <= 1'b0;
      r_Busy  <= 1'b0;
      r_Done  <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      if (w_Adv) begin
        r_Valid <= w_Has;
        if (w_Has) begin
          r_Data <= w_Byte;
          r_Mark <= w_MarkBit;
        end
      end
      unique case (r_State)
        ST_IDLE: begin
          if (i_Start) begin
            r_State <= ST_SYNC;
            r_Del   <= i_Deleted;
            r_Busy  <= 1'b1;
            r_Cnt   <= '0;
          end
        end
        ST_SYNC: begin
          if (w_Load) begin
            if (r_Cnt == L_SYNC) begin
              r_State <= ST_MARK;
              r_Cnt   <= '0;
            end else begin
              r_Cnt <= r_Cnt + 10'd1;
            end
          end
        end
        ST_MARK: begin
          if (w_Load) begin
            if (r_Cnt == L_MARK) begin
              r_State <= ST_DAM;
              r_Cnt   <= '0;
            end else begin
              r_Cnt <= r_Cnt + 10'd1;
            end
          end
        end
        ST_DAM: begin
          if (w_Load) begin
            r_State <= ST_DATA;
            r_Cnt   <= '0;
          end
        end
        ST_DATA: begin
          if (w_Load) begin
            if (r_Cnt == L_DATA) begin
              r_State <= ST_CRC_HI;
              r_Cnt   <= '0;
            end else begin
              r_Cnt <= r_Cnt + 10'd1;
            end
          end
        end
        ST_CRC_HI: begin
          if (w_Load) r_State <= ST_CRC_LO;
        end
        ST_CRC_LO: begin
          if (w_Load) begin
            r_State <= ST_GAP;
            r_Cnt   <= '0;
          end
        end
        ST_GAP: begin
          if (w_Load) begin
            r_Cnt <= r_Cnt + 10'd1;
          end else if ((r_Cnt == L_GAPW) && w_Accept) begin
            r_State <= ST_DONE;
            r_Cnt   <= '0;
            r_Busy  <= 1'b0;
            r_Done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_State <= ST_IDLE;
        end
        default: begin
          r_State <= ST_IDLE;
          r_Cnt   <= '0;
        end
      endcase
    end
  end

  assign o_Data  = r_Data;
  assign o_Mark  = r_Mark;
  assign o_Valid = r_Valid;
  assign o_Busy  = r_Busy;
  assign o_Done  = r_Done;

endmodule

// File: tb/tb_sector_data_writer.sv
// Randomized bench for sector_data_writer against a queue-based
// model of the complete data field.
module tb_sector_data_writer;

  logic       clk = 1'b0;
  logic       i_Reset_n;
  logic       i_Start;
  logic       i_Deleted;
  logic       i_Abort;
  logic [7:0] i_Data;
  logic       i_DataValid;
  logic       o_DataReady;
  logic [7:0] o_Data;
  logic       o_Mark;
  logic       o_Valid;
  logic       i_Ready;
  logic       o_Busy;
  logic       o_Done;

  always #5 clk = ~clk;

  sector_data_writer dut (
    .i_Clk       (clk),
    .i_Reset_n   (i_Reset_n),
    .i_Start     (i_Start),
    .i_Deleted   (i_Deleted),
    .i_Abort     (i_Abort),
    .i_Data      (i_Data),
    .i_DataValid (i_DataValid),
    .o_DataReady (o_DataReady),
    .o_Data      (o_Data),
    .o_Mark      (o_Mark),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       m;
  } ent_t;

  ent_t        expq[$];
  ent_t        e;
  logic [7:0]  pay [0:511];
  int          nerr = 0;
  int          nchk = 0;
  int          pay_cnt = 0;
  int          acc_cnt = 0;
  int          cyc = 0;
  int          first_acc = 0;
  int          last_acc = 0;
  int          sv_n = 0;
  bit          bp = 1'b0;
  bit          starve_en = 1'b0;
  bit          exp_busy = 1'b0;
  bit          done_due = 1'b0;
  bit          got_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  pd;
  logic        pm;
  logic [15:0] last_crc;
  logic [15:0] crc_norm;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // bit-serial reference CRC, one input bit per shift
  function automatic logic [15:0] mcrc(input logic [15:0] c,
                                       input logic [7:0] b);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic build_field(input logic del);
    logic [15:0] c;
    logic [7:0]  dm;
    expq.delete();
    c = 16'hFFFF;
    repeat (12) expq.push_back('{8'h00, 1'b0});
    repeat (3) begin
      expq.push_back('{8'hA1, 1'b1});
      c = mcrc(c, 8'hA1);
    end
    dm = del ? 8'hFA : 8'hFB;
    expq.push_back('{dm, 1'b0});
    c = mcrc(c, dm);
    for (int i = 0; i < 512; i++) begin
      expq.push_back('{pay[i], 1'b0});
      c = mcrc(c, pay[i]);
    end
    expq.push_back('{c[15:8], 1'b0});
    expq.push_back('{c[7:0], 1'b0});
    repeat (24) expq.push_back('{8'h4E, 1'b0});
    last_crc = c;
    chk("field_len", 32'(expq.size()), 32'd554);
  endtask

  always @(posedge clk) begin
    #1;
    i_Ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pay_cnt < 100) sv_n = 0;
    if (starve_en && pay_cnt == 100 && sv_n < 5) begin
      i_DataValid = 1'b0;
      sv_n++;
    end else begin
      i_DataValid = 1'b1;
    end
    i_Data = pay[9'(pay_cnt)];
  end

  always @(negedge clk) begin
    cyc++;
    if (!i_Reset_n) begin
      expq.delete();
      exp_busy   = 1'b0;
      done_due   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done", 32'(o_Done), 32'(done_due));
      if (o_Done && done_due) got_done = 1'b1;
      done_due = 1'b0;
      chk("busy", 32'(o_Busy), 32'(exp_busy));
      if (expq.size() == 0) chk("idle_valid", 32'(o_Valid), 32'd0);
      if (o_DataReady)
        chk("dready_window",
            32'(exp_busy && acc_cnt >= 15 && pay_cnt < 512), 32'd1);
      if (prev_stall)
        chk("stall_hold", 32'({o_Valid, o_Mark, o_Data}),
            32'({1'b1, pm, pd}));
      prev_stall = 1'b0;
      if (i_Abort && exp_busy) begin
        expq.delete();
        exp_busy = 1'b0;
      end else begin
        if (o_Valid && !i_Ready) begin
          prev_stall = 1'b1;
          pd = o_Data;
          pm = o_Mark;
        end
        if (i_DataValid && o_DataReady) pay_cnt++;
        if (o_Valid && i_Ready && expq.size() > 0) begin
          e = expq.pop_front();
          chk($sformatf("byte%0d", acc_cnt), 32'({o_Mark, o_Data}),
              32'({e.m, e.d}));
          if (acc_cnt == 0) first_acc = cyc;
          last_acc = cyc;
          acc_cnt++;
          if (expq.size() == 0) begin
            done_due = 1'b1;
            exp_busy = 1'b0;
          end
        end
        if (i_Start && !exp_busy) begin
          build_field(i_Deleted);
          pay_cnt  = 0;
          acc_cnt  = 0;
          got_done = 1'b0;
          exp_busy = 1'b1;
        end
      end
    end
  end

  task automatic pulse_start(input logic del);
    @(posedge clk);
    #2;
    i_Start   = 1'b1;
    i_Deleted = del;
    @(posedge clk);
    #2;
    i_Start   = 1'b0;
    i_Deleted = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      if (got_done) break;
    end
    chk(nm, 32'(got_done), 32'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_acc(input int n, input bit use_pay);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      if ((use_pay ? pay_cnt : acc_cnt) >= n) begin
        hit = 1'b1;
        break;
      end
    end
    chk("wait_point", 32'(hit), 32'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 32'({o_Valid, o_Mark, o_Busy, o_Done, o_DataReady, o_Data}),
        32'd0);
  endtask

  initial begin
    logic [15:0] c;
    logic [7:0]  s [0:8];
    i_Reset_n   = 1'b1;
    i_Start     = 1'b0;
    i_Deleted   = 1'b0;
    i_Abort     = 1'b0;
    i_Data      = 8'h00;
    i_DataValid = 1'b0;
    i_Ready     = 1'b0;
    for (int i = 0; i < 512; i++) pay[i] = 8'(i);

    c = 16'hFFFF;
    repeat (3) c = mcrc(c, 8'hA1);
    chk("model_a1x3", 32'(c), 32'hCDB4);
    for (int i = 0; i < 9; i++) s[i] = 8'h31 + 8'(i);
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) c = mcrc(c, s[i]);
    chk("model_123456789", 32'(c), 32'h29B1);

    #1 i_Reset_n = 1'b0;
    #2 chk_zero("reset_state");
    repeat (2) @(posedge clk);
    #2 i_Reset_n = 1'b1;

    pulse_start(1'b0);
    wait_done("done_normal");
    chk("throughput_span", 32'(last_acc - first_acc), 32'd553);
    crc_norm = last_crc;

    pulse_start(1'b1);
    wait_done("done_deleted");
    chk("crc_deleted_differs", 32'(last_crc != crc_norm), 32'd1);

    bp = 1'b1;
    pulse_start(1'b0);
    wait_done("done_backpressure");
    chk("crc_bp_same", 32'(last_crc), 32'(crc_norm));
    bp = 1'b0;

    starve_en = 1'b1;
    pulse_start(1'b0);
    wait_done("done_starve");
    chk("starve_span", 32'(last_acc - first_acc), 32'd558);
    starve_en = 1'b0;

    for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
    pulse_start(1'b0);
    wait_acc(37, 1'b1);
    #2 i_Abort = 1'b1;
    @(posedge clk);
    #2 i_Abort = 1'b0;
    chk("abort_valid", 32'(o_Valid), 32'd0);
    chk("abort_busy", 32'(o_Busy), 32'd0);
    chk("abort_dready", 32'(o_DataReady), 32'd0);
    repeat (20) @(posedge clk);
    bp = 1'b1;
    pulse_start(1'b1);
    wait_done("done_after_abort");
    bp = 1'b0;

    pulse_start(1'b0);
    wait_acc(300, 1'b0);
    pulse_start(1'b1);
    wait_done("done_busy_start");
    repeat (40) @(posedge clk);

    pulse_start(1'b0);
    wait_acc(545, 1'b0);
    #3 i_Reset_n = 1'b0;
    #1 chk_zero("async_reset_gap");
    repeat (2) @(posedge clk);
    #2 i_Reset_n = 1'b1;
    repeat (5) @(posedge clk);
    pulse_start(1'b0);
    wait_done("done_after_reset");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sector_data_writer.md
Name: sector_data_writer

Overview:
Transmit-side formatter for the MFM floppy data field. On a start pulse it emits a complete data field as a byte stream to the MFM encoder: sync zeros, three A1 address-mark bytes flagged for missing-clock encoding, the FB/FA data mark, SECTOR_SIZE payload bytes pulled from the sector buffer, CRC-16 high then low, and a trailing gap. The block sits between the sector buffer and the MFM bit encoder on the write path.

Parameters:
SECTOR_SIZE, 512, payload bytes per sector
SYNC_LEN, 12, number of 8'h00 preamble bytes
GAP_LEN, 24, number of 8'h4E trailing gap bytes

Ports:
i_Clk  input  1  system clock; the block's one clock
i_Reset_n  input  1  reset, asynchronous and active-low
i_Start  input  1  one-cycle pulse; begins a field when idle
i_Deleted  input  1  sampled with i_Start: 1 = data mark FA, 0 = FB
i_Abort  input  1  terminate the current field immediately
i_Data  input  8  payload byte from sector buffer
i_DataValid  input  1  i_Data valid
o_DataReady  output  1  payload byte accepted when i_DataValid && o_DataReady
o_Data  output  8  byte to MFM encoder
o_Mark  output  1  o_Data is an A1 address mark (missing-clock encoding)
o_Valid  output  1  o_Data/o_Mark valid
i_Ready  input  1  encoder consumes byte when o_Valid && i_Ready
o_Busy  output  1  high from accepted start until the last gap byte is accepted
o_Done  output  1  one-cycle pulse after the last gap byte is accepted

Behaviour:
- Reset (i_Reset_n low, asynchronous): state IDLE, counter 0, CRC 16'hFFFF; o_Valid, o_Mark, o_Busy, o_Done, o_DataReady = 0; o_Data = 0.
- Output stage is a one-entry register. It loads a new byte when (!o_Valid || i_Ready) and the FSM has a byte; otherwise o_Valid drops to 0 once the byte is accepted. A byte offered by the FSM appears on o_Data one cycle later. o_Data and o_Mark stay stable while o_Valid && !i_Ready.
- FSM states and output bytes:
  - IDLE: i_Start -> SYNC; latch i_Deleted; CRC := FFFF.
  - SYNC: SYNC_LEN x 00 -> MARK.
  - MARK: 3 x A1 with o_Mark=1 -> DAM.
  - DAM: FB (or FA if latched deleted) -> DATA.
  - DATA: SECTOR_SIZE bytes -> CRC_HI.
  - CRC_HI: CRC[15:8] -> CRC_LO.
  - CRC_LO: CRC[7:0] -> GAP.
  - GAP: GAP_LEN x 4E; after the last gap byte is accepted -> DONE.
  - DONE: o_Done=1 for one cycle -> IDLE.
- o_Mark is 0 for every byte outside MARK.
- DATA: o_DataReady = (state==DATA) && (!o_Valid || i_Ready) && payload count < SECTOR_SIZE. The payload byte passes straight into the output register. A starved source (i_DataValid=0) produces an o_Valid gap and is not an error.
- CRC: CCITT, poly 16'h1021, MSB-first, init FFFF. Covers the 3 A1 bytes, the data mark and all payload bytes; it does not cover sync, CRC or gap bytes. CRC is updated in the cycle a byte loads into the output register.
- Counter: 10 bits, shared by SYNC, MARK, DATA and GAP. Cleared on every state change. Terminal count is N-1 on load.
- i_Start while busy: ignored.
- i_Abort (any non-IDLE state): next cycle state IDLE, o_Valid=0, o_Busy=0, o_DataReady=0, no o_Done; the in-flight output byte is dropped. Abort takes priority over a simultaneous i_Start.
- i_Start in the same cycle as o_Done: ignored; the field is accepted from the next cycle.
- Total field length with defaults: 12+3+1+512+2+24 = 554 bytes.
- Throughput: one byte per cycle when i_Ready and i_DataValid are held high.

Decomposition:
- Package floppy_pkg holds:
  - constants MFM_A1=8'hA1, DAM_NORMAL=8'hFB, DAM_DELETED=8'hFA, GAP_BYTE=8'h4E, SYNC_BYTE=8'h00, CRC_INIT=16'hFFFF, CRC_POLY=16'h1021;
  - state encoding localparams;
  - function crc16_byte(crc, data), shared with the receive path.
- Sub-module crc16_ccitt: combinational byte-wide next-CRC with registered accumulator, init/enable inputs.

Test Plan:
- Reset, then i_Start with i_Ready=1, i_DataValid=1 and payload 00..FF repeated -> 554 consecutive o_Valid bytes in the field order above, o_Mark=1 exactly on bytes 13-15, o_Done one cycle after the final 4E is accepted.
- CRC check: state after the 3 A1s = 16'hCDB4. CRC bytes on the stream must equal the software crc16_byte model over A1 A1 A1 FB plus payload. A second run with i_Deleted=1 gives mark FA and a differing CRC matching the model.
- Backpressure: toggle i_Ready in a pseudo-random 50% pattern -> o_Data/o_Mark stable while stalled, no byte lost or duplicated, byte count 554, CRC unchanged from the free-running case.
- Source starvation: deassert i_DataValid for 5 cycles at payload byte 100 -> o_Valid bubble, stream contents identical, o_DataReady never asserted outside DATA.
- Abort at payload byte 37 -> IDLE next cycle, o_Valid=0, no o_Done; a new i_Start produces a full, correct 554-byte field.
- Async reset pulse mid-GAP and an i_Start issued while o_Busy=1 -> reset clears all outputs without a clock edge; the busy-time start produces no second field.
